vsng: RTL

- Variable-precision stochastic number generator; the binary-to-stream counterpart of the team's variable-shift binary counter.
- Converts a W-bit binary value into a unipolar bitstream Z using a van der Corput (bit-reversed counter) source.
- Supports progressive precision: each rshift halves the stream length, so a downstream counter can terminate early on a power-of-two boundary.
- Sits at the input side of the SC datapath and feeds the counter through a valid/ready/last stream.

---
 rtl/sc_pkg.sv | 24 ++
 rtl/vsng_vdc.sv | 28 ++
 rtl/vsng.sv | 101 ++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath blocks.
// Holds the generator state encoding and the bit-reversal helper used by SNG/decoder sources.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vsng_state_t;

  localparam int BITREV_MAX_W = 32;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                      input int n);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < n) r[n-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/vsng_vdc.sv
// van der Corput source: beat counter plus its bit-reversed view.
// The counter only moves on an accepted beat so the sequence survives backpressure.
module vdc_source
  import sc_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [TW-1:0] cnt,
  output logic [TW-1:0] r
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign r = TW'(bitrev(32'(cnt), TW));

endmodule

// File: rtl/vsng.sv
// Variable-precision stochastic number generator: W-bit value to unipolar bitstream.
// Stream length 2^L shrinks by half per rshift so the consumer can stop on a power-of-two boundary.
module vsng
  import sc_pkg::*;
#(
  parameter int W  = 4,
  parameter int TW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic         rshift,
  input  logic         term,
  output logic         z,
  output logic         z_valid,
  input  logic         z_ready,
  output logic         z_last,
  output logic         busy,
  output logic         done
);

  localparam int LW = $clog2(TW + 1);

  vsng_state_t   state, state_nxt;
  logic [LW-1:0] l_q, l_eff;
  logic [TW-1:0] x_q;
  logic [TW-1:0] cnt, r;
  logic [TW:0]   limit;
  logic          in_run, in_idle, launch, accept, last_hit;

  assign in_run  = (state == RUN);
  assign in_idle = (state == IDLE);
  assign launch  = in_idle && start;
  assign accept  = in_run && z_ready && !term;

  vdc_source #(.TW(TW)) u_vdc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .inc   (accept),
    .cnt   (cnt),
    .r     (r)
  );

  // Same-cycle rshift already shortens the stream, so an overshooting cnt ends it on this beat.
  assign l_eff    = (in_run && rshift && !term && (l_q != '0)) ? l_q - LW'(1) : l_q;
  assign limit    = ((TW+1)'(1) << l_eff) - (TW+1)'(1);
  assign last_hit = ({1'b0, cnt} >= limit);

  assign z      = in_run && (x_q > r);
  assign z_last = in_run && last_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q <= LW'(TW);
      x_q <= '0;
    end else if (launch) begin
      l_q <= LW'(TW);
      x_q <= TW'(x_in) << (TW - W);
    end else if (in_run) begin
      l_q <= l_eff;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (term) state_nxt = DONE;
        else if (accept && last_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    z_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      RUN: begin
        z_valid = 1'b1;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
